// File: rtl/popcount21_ternary_seq_if.sv
// popcount21_ternary_seq_if: config, chunk, shared-popcount and result signals of the ternary neuron
interface popcount21_ternary_seq_if #(parameter int ACC_W = 9);
   logic                    cfg_we;
   logic signed [ACC_W-1:0] cfg_thr_hi;
   logic signed [ACC_W-1:0] cfg_thr_lo;
   logic                    in_valid;
   logic                    in_ready;
   logic [20:0]             in_pos;
   logic [20:0]             in_neg;
   logic                    in_last;
   logic [20:0]             pc_operand;
   logic [4:0]              pc_result;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_sum;
   logic [1:0]              out_act;
   logic                    out_ovf;
   modport master (
      output cfg_we, cfg_thr_hi, cfg_thr_lo, in_valid, in_pos, in_neg, in_last, pc_result, out_ready,
      input  in_ready, pc_operand, out_valid, out_sum, out_act, out_ovf
   );
   modport slave (
      input  cfg_we, cfg_thr_hi, cfg_thr_lo, in_valid, in_pos, in_neg, in_last, pc_result, out_ready,
      output in_ready, pc_operand, out_valid, out_sum, out_act, out_ovf
   );
endinterface

// File: rtl/popcount21_ternary_seq.sv
// popcount21_ternary_seq: ternary-weight neuron, one shared popcount21 time-multiplexed over pos/neg words
module popcount21_ternary_seq #(
   parameter int MAX_CHUNKS = 8,
   parameter int ACC_W      = 9
) (
   input logic                         clk,
   input logic                         rst_n,
   popcount21_ternary_seq_if.slave     bus
);
   localparam int CW = $clog2(MAX_CHUNKS + 1);
   typedef enum logic [1:0] {IDLE, POS, NEG, OUT} state_t;
   state_t                  r_state;
   logic signed [ACC_W-1:0] r_acc, r_thr_hi, r_thr_lo;
   logic [CW-1:0]           r_cnt;
   logic                    r_ovf, r_last;
   logic [20:0]             r_pos, r_neg;
   logic signed [ACC_W-1:0] w_pc;
   logic                    w_done;
   assign w_pc   = $signed({{(ACC_W-5){1'b0}}, bus.pc_result});
   assign w_done = r_last || (r_cnt == CW'(MAX_CHUNKS));
   assign bus.in_ready   = (r_state == IDLE);
   assign bus.out_valid  = (r_state == OUT);
   assign bus.out_sum    = r_acc;
   assign bus.out_ovf    = r_ovf;
   assign bus.out_act    = (r_acc >= r_thr_hi) ? 2'b01 : (r_acc <= r_thr_lo) ? 2'b11 : 2'b00;
   assign bus.pc_operand = (r_state == POS) ? r_pos : (r_state == NEG) ? r_neg : 21'd0;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
         r_last   <= 1'b0;
         r_thr_hi <= ACC_W'(1);
         r_thr_lo <= -ACC_W'(1);
         r_pos    <= '0;
         r_neg    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // thresholds only change between neurons, never mid-evaluation
               if (bus.cfg_we && r_cnt == '0) begin
                  r_thr_hi <= bus.cfg_thr_hi;
                  r_thr_lo <= bus.cfg_thr_lo;
               end
               if (bus.in_valid) begin
                  r_pos   <= bus.in_pos;
                  r_neg   <= bus.in_neg;
                  r_last  <= bus.in_last;
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= POS;
               end
            end
            POS: begin
               r_acc   <= r_acc + w_pc;
               r_state <= NEG;
            end
            NEG: begin
               r_acc   <= r_acc - w_pc;
               r_ovf   <= w_done && !r_last;
               r_state <= w_done ? OUT : IDLE;
            end
            OUT: begin
               if (bus.out_ready) begin
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_popcount21_ternary_seq.sv
// tb_popcount21_ternary_seq: directed checks of the ternary neuron with an exact popcount model
module tb_popcount21_ternary_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_tot = 0;
   popcount21_ternary_seq_if #(.ACC_W(9)) bus ();
   popcount21_ternary_seq #(.MAX_CHUNKS(8), .ACC_W(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.pc_result = 5'($countones(bus.pc_operand));
   function automatic logic [20:0] ones(input int n);
      logic [20:0] one = 21'h1;
      return (one << n) - one;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask
   task automatic set_thr(input int hi, input int lo);
      bus.cfg_we = 1'b1;
      bus.cfg_thr_hi = 9'(hi);
      bus.cfg_thr_lo = 9'(lo);
      tick();
      bus.cfg_we = 1'b0;
   endtask
   task automatic send(input int p, input int n, input logic last);
      chk("ready_idle", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_pos = ones(p);
      bus.in_neg = ones(n);
      bus.in_last = last;
      tick();
      bus.in_valid = 1'b0;
      chk("ready_pos", 32'(bus.in_ready), 0);
      chk("opnd_pos", 32'(bus.pc_operand), 32'(ones(p)));
      tick();
      chk("ready_neg", 32'(bus.in_ready), 0);
      chk("opnd_neg", 32'(bus.pc_operand), 32'(ones(n)));
      chk("valid_neg", 32'(bus.out_valid), 0);
      tick();
   endtask
   task automatic result(input string tag, input int sum, input int act, input int ovf);
      chk({tag, "_valid"}, 32'(bus.out_valid), 1);
      chk({tag, "_sum"}, 32'(bus.out_sum), sum);
      chk({tag, "_act"}, 32'(bus.out_act), act);
      chk({tag, "_ovf"}, 32'(bus.out_ovf), ovf);
      chk({tag, "_ready"}, 32'(bus.in_ready), 0);
      chk({tag, "_opnd"}, 32'(bus.pc_operand), 0);
   endtask
   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("post_valid", 32'(bus.out_valid), 0);
      chk("post_ready", 32'(bus.in_ready), 1);
      chk("post_sum", 32'(bus.out_sum), 0);
      chk("post_ovf", 32'(bus.out_ovf), 0);
   endtask
   initial begin
      bus.cfg_we = 1'b0;
      bus.cfg_thr_hi = '0;
      bus.cfg_thr_lo = '0;
      bus.in_valid = 1'b0;
      bus.in_pos = '0;
      bus.in_neg = '0;
      bus.in_last = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_ready", 32'(bus.in_ready), 1);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_sum", 32'(bus.out_sum), 0);
      chk("rst_act", 32'(bus.out_act), 0);
      chk("rst_ovf", 32'(bus.out_ovf), 0);
      chk("rst_opnd", 32'(bus.pc_operand), 0);
      rst_n = 1'b1;
      tick();
      chk("rel_ready", 32'(bus.in_ready), 1);
      set_thr(5, -5);
      send(21, 0, 1'b1);
      result("full", 21, 1, 0);
      consume();
      send(3, 7, 1'b0);
      chk("mid1_valid", 32'(bus.out_valid), 0);
      send(0, 4, 1'b0);
      chk("mid2_valid", 32'(bus.out_valid), 0);
      send(2, 1, 1'b1);
      result("three", -7, 3, 0);
      consume();
      for (int i = 0; i < 8; i++) begin
         send(1, 0, 1'b0);
         if (i == 6) chk("ovf7_valid", 32'(bus.out_valid), 0);
      end
      result("ovf", 8, 1, 1);
      consume();
      send(2, 0, 1'b1);
      result("after_ovf", 2, 0, 0);
      consume();
      send(0, 6, 1'b1);
      bus.cfg_thr_hi = -9'sd100;
      bus.cfg_thr_lo = -9'sd200;
      for (int i = 0; i < 5; i++) begin
         bus.cfg_we = i[0] ? 1'b0 : 1'b1;
         tick();
         result("hold", -6, 3, 0);
      end
      bus.cfg_we = 1'b0;
      consume();
      send(0, 5, 1'b1);
      result("thr_kept", -5, 3, 0);
      consume();
      send(3, 0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_pos = ones(9);
      bus.in_neg = ones(2);
      bus.in_last = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("abort_in_neg", 32'(bus.pc_operand), 32'(ones(2)));
      rst_n = 1'b0;
      tick();
      chk("abort_valid", 32'(bus.out_valid), 0);
      chk("abort_ready", 32'(bus.in_ready), 1);
      chk("abort_sum", 32'(bus.out_sum), 0);
      rst_n = 1'b1;
      send(4, 0, 1'b1);
      result("after_rst", 4, 1, 0);
      consume();
      set_thr(0, 0);
      send(1, 1, 1'b1);
      result("hi_prio", 0, 1, 0);
      consume();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
